pc_fetch_unit: RTL

//  Owns the architectural PC and fetches instructions for decode; far end of the branch-resolution interface.

---
 rtl/wisc_pkg.sv | 20 ++
 rtl/pc_incr.sv | 15 +
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC front end (fetch, PC_control, decode).
// Holds the fetch FSM state type, datapath widths and the architectural
// reset/halt constants so every consumer agrees on them.
package wisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT   = 16'h0000;
  localparam logic [3:0]        HLT_OPCODE_DEFAULT = 4'hF;

  // Fetch sequencer states: BOOT idles for one cycle after reset, RUN
  // fetches continuously, HALT is terminal until reset.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_incr.sv
// Sequential-PC adder: returns pc + 2, wrapping modulo 2^16 with no carry
// out. Also used by PC_control for its not-taken path.
// Ports:
//   pc        in   ADDR_W  current program counter
//   pc_plus2  out  ADDR_W  pc + 2 (wraps 16'hFFFE -> 16'h0000)
module pc_incr
  import wisc_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2
);

  assign pc_plus2 = pc + ADDR_W'(2);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the architectural PC, issues instruction-memory requests
// and holds the fetch->decode register. Squashes the wrong-path fetch when
// PC_control resolves a taken branch for the instruction in decode, and
// stops fetching permanently (until reset) when HLT reaches decode.
// Ports:
//   clk           in   1        rising-edge clock
//   rst_n         in   1        synchronous reset, active-low
//   stall         in   1        hold all state this cycle
//   branch_taken  in   1        taken resolution for dec_instr (needs dec_valid)
//   next_pc       in   ADDR_W   branch target from PC_control
//   imem_req      out  1        fetch request (state-derived only)
//   imem_addr     out  ADDR_W   fetch address (the pc register)
//   imem_rdy      in   1        imem_data valid for imem_addr this cycle
//   imem_data     in   INSTR_W  fetched instruction word
//   dec_instr     out  INSTR_W  instruction in decode
//   dec_valid     out  1        dec_instr is live
//   dec_pc        out  ADDR_W   address of dec_instr, feeds PC_control.PC_in
//   halted        out  1        sticky HLT indicator
module pc_fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  next_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] dec_instr,
  output logic               dec_valid,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               halted
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus2;

  logic do_flush;
  logic do_halt;

  pc_incr u_pc_incr (
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    do_flush = 1'b0;
    do_halt  = 1'b0;
    if (dec_valid) begin
      do_flush = branch_taken;
      do_halt  = (dec_instr[15:12] == HLT_OPCODE);
    end
  end

  // Request is a pure function of the registered state, so there is no
  // combinational path from any input to imem_req.
  assign imem_req  = (state == ST_RUN);
  assign imem_addr = pc;

  // NOTE: state registers use non-blocking assignments so every flop in
  // this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      dec_instr <= '0;
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;

        ST_RUN: begin
          // Priority: stall > flush > halt > fetch > bubble.
          if (stall) begin
            // Hold everything; the same address is re-requested.
          end else if (do_flush) begin
            // Instruction addresses are halfword aligned.
            pc        <= {next_pc[ADDR_W-1:1], 1'b0};
            dec_valid <= 1'b0;
          end else if (do_halt) begin
            // pc already points at HLT+2 from the fetch that brought it in.
            state     <= ST_HALT;
            halted    <= 1'b1;
            dec_valid <= 1'b0;
          end else if (imem_rdy) begin
            dec_instr <= imem_data;
            dec_pc    <= pc;
            dec_valid <= 1'b1;
            pc        <= pc_plus2;
          end else begin
            dec_valid <= 1'b0;
          end
        end

        ST_HALT: begin
          // Terminal: only reset leaves this state.
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
